// File: rtl/snoop_bus_arbiter_if.sv
// Bus between the per-cache coherence controllers and the snoop bus arbiter.
// The arbiter side uses modport master; caches (or a bench) use slave.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CACHES = 4
);
    logic [3*NUM_CACHES-1:0] req_in;
    logic [NUM_CACHES-1:0]   grant_out;
    logic [2*NUM_CACHES-1:0] snoop_out;
    logic                    mem_rd_out;
    logic                    mem_wr_out;
    logic [NUM_CACHES-1:0]   done_out;
    logic                    busy_out;

    modport master (
        input  req_in,
        output grant_out, snoop_out, mem_rd_out, mem_wr_out, done_out, busy_out
    );

    modport slave (
        output req_in,
        input  grant_out, snoop_out, mem_rd_out, mem_wr_out, done_out, busy_out
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter for MSI caches: sequences write-back, fetch
// and a one-cycle snoop broadcast per transaction, then pulses done.
module snoop_bus_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int MEM_LAT    = 3
) (
    input  logic                clk,
    input  logic                rst,
    snoop_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_CACHES);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WB, MISS, DONE} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           ptr, ptr_n, gidx, gidx_n, win;
    logic [2:0]              lreq, lreq_n;
    logic [NUM_CACHES-1:0]   grant, grant_n, done, done_n;
    logic [2*NUM_CACHES-1:0] snoop, snoop_n;
    logic                    mem_rd, mem_rd_n, mem_wr, mem_wr_n, found;

    // Write miss wins when both miss bits are set; requester sees no snoop.
    function automatic logic [2*NUM_CACHES-1:0] snoop_vec(input logic [2:0] r,
                                                          input logic [IW-1:0] g);
        logic [2*NUM_CACHES-1:0] s;
        s = '0;
        for (int j = 0; j < NUM_CACHES; j++) begin
            if (j != int'(g)) begin
                s[2*j+1] = r[2] & ~r[1];
                s[2*j]   = r[1];
            end
        end
        return s;
    endfunction

    always_comb begin
        int w;
        w     = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CACHES; k++) begin
            w = int'(ptr) + k;
            if (w >= NUM_CACHES) w = w - NUM_CACHES;
            if (!found && bus.req_in[3*w +: 3] != 3'b000) begin
                found = 1'b1;
                win   = IW'(w);
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        gidx_n   = gidx;
        lreq_n   = lreq;
        grant_n  = grant;
        done_n   = '0;
        snoop_n  = '0;
        mem_rd_n = 1'b0;
        mem_wr_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gidx_n       = win;
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    lreq_n       = bus.req_in[3*int'(win) +: 3];
                    cnt_n        = CW'(MEM_LAT - 1);
                    if (lreq_n[0]) begin
                        state_n  = WB;
                        mem_wr_n = 1'b1;
                    end else begin
                        state_n  = MISS;
                        mem_rd_n = 1'b1;
                        snoop_n  = snoop_vec(lreq_n, win);
                    end
                end
            end
            WB: begin
                if (cnt == '0) begin
                    if (lreq[2] | lreq[1]) begin
                        state_n  = MISS;
                        mem_rd_n = 1'b1;
                        snoop_n  = snoop_vec(lreq, gidx);
                        cnt_n    = CW'(MEM_LAT - 1);
                    end else begin
                        state_n = DONE;
                        done_n  = grant;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            MISS: begin
                if (cnt == '0) begin
                    state_n = DONE;
                    done_n  = grant;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = (int'(gidx) == NUM_CACHES - 1) ? '0 : gidx + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            gidx   <= '0;
            lreq   <= '0;
            grant  <= '0;
            done   <= '0;
            snoop  <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            gidx   <= gidx_n;
            lreq   <= lreq_n;
            grant  <= grant_n;
            done   <= done_n;
            snoop  <= snoop_n;
            mem_rd <= mem_rd_n;
            mem_wr <= mem_wr_n;
        end
    end

    assign bus.grant_out  = grant;
    assign bus.done_out   = done;
    assign bus.snoop_out  = snoop;
    assign bus.mem_rd_out = mem_rd;
    assign bus.mem_wr_out = mem_wr;
    assign bus.busy_out   = (state != IDLE);
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: transaction-timeline model checked
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_snoop_bus_arbiter;
    localparam int N = 4;
    localparam int L = 3;

    logic clk;
    logic rst;
    snoop_bus_arbiter_if #(.NUM_CACHES(N)) bus ();

    snoop_bus_arbiter #(.NUM_CACHES(N), .MEM_LAT(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one transaction as a timeline of edge numbers relative to grant.
    bit             mvalid = 0;
    int             cyc = 0;
    bit             act = 0;
    int             t0, tmiss, tdone, free_at, g, mptr;
    bit             has_wb, has_miss;
    logic [2:0]     r;
    logic [N-1:0]   e_grant, e_done;
    logic [2*N-1:0] e_snoop;
    logic           e_rd, e_wr, e_busy;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            act = 0; mptr = 0; free_at = cyc + 1; mvalid = 1;
        end else begin
            if (act && cyc > tdone) begin
                act  = 0;
                mptr = (g + 1) % N;
            end
            if (!act && cyc >= free_at) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (mptr + k) % N;
                    if (!act && bus.req_in[3*c +: 3] != 3'b000) begin
                        act = 1; g = c; r = bus.req_in[3*c +: 3];
                    end
                end
                if (act) begin
                    t0       = cyc;
                    has_wb   = r[0];
                    has_miss = r[2] | r[1];
                    tmiss    = t0 + (has_wb ? L : 0);
                    tdone    = tmiss + (has_miss ? L : 0);
                    free_at  = tdone + 2;
                end
            end
        end
        e_grant = act ? (N'(1) << g) : '0;
        e_busy  = act;
        e_wr    = act && has_wb && cyc == t0;
        e_rd    = act && has_miss && cyc == tmiss;
        e_done  = (act && cyc == tdone) ? (N'(1) << g) : '0;
        e_snoop = '0;
        if (e_rd)
            for (int j = 0; j < N; j++)
                if (j != g) begin
                    if (r[1]) e_snoop[2*j] = 1'b1;
                    else      e_snoop[2*j+1] = 1'b1;
                end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            n_vec++;
            if ({bus.grant_out, bus.snoop_out, bus.mem_rd_out, bus.mem_wr_out, bus.done_out, bus.busy_out}
                !== {e_grant, e_snoop, e_rd, e_wr, e_done, e_busy}) begin
                n_err++;
                $display("FAIL model cyc %0d: got grant=%b snoop=%b rd=%b wr=%b done=%b busy=%b, want grant=%b snoop=%b rd=%b wr=%b done=%b busy=%b",
                         cyc, bus.grant_out, bus.snoop_out, bus.mem_rd_out, bus.mem_wr_out, bus.done_out, bus.busy_out,
                         e_grant, e_snoop, e_rd, e_wr, e_done, e_busy);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act_v, exp_v);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.req_in = '0;
        tick();
        lit("reset grant", 32'(bus.grant_out), 32'h0);
        lit("reset busy", 32'(bus.busy_out), 32'h0);
        tick();
        rst = 1'b1;

        // cache1 read miss
        bus.req_in = 12'h020;
        tick();
        lit("rm grant", 32'(bus.grant_out), 32'h2);
        lit("rm mem_rd", 32'(bus.mem_rd_out), 32'h1);
        lit("rm snoop", 32'(bus.snoop_out), 32'hA2);
        bus.req_in = '0;
        tick(3);
        lit("rm done", 32'(bus.done_out), 32'h2);
        tick();
        lit("rm busy low", 32'(bus.busy_out), 32'h0);

        // cache2 write-back + read miss
        bus.req_in = 12'h140;
        tick();
        lit("wbrm grant", 32'(bus.grant_out), 32'h4);
        lit("wbrm mem_wr", 32'(bus.mem_wr_out), 32'h1);
        bus.req_in = '0;
        tick(3);
        lit("wbrm mem_rd", 32'(bus.mem_rd_out), 32'h1);
        lit("wbrm snoop", 32'(bus.snoop_out), 32'h8A);
        tick(3);
        lit("wbrm done", 32'(bus.done_out), 32'h4);
        tick();

        // cache3 write-back only
        bus.req_in = 12'h200;
        tick();
        lit("wb mem_wr", 32'(bus.mem_wr_out), 32'h1);
        lit("wb snoop", 32'(bus.snoop_out), 32'h0);
        bus.req_in = '0;
        tick(3);
        lit("wb done", 32'(bus.done_out), 32'h8);
        tick();

        // caches 0 and 3 write-missing continuously from reset
        rst = 1'b0;
        bus.req_in = 12'h402;
        tick();
        rst = 1'b1;
        tick();
        lit("rr grant 1", 32'(bus.grant_out), 32'h1);
        lit("rr snoop 1", 32'(bus.snoop_out), 32'h54);
        tick(5);
        lit("rr grant 2", 32'(bus.grant_out), 32'h8);
        lit("rr snoop 2", 32'(bus.snoop_out), 32'h15);
        tick(5);
        lit("rr grant 3", 32'(bus.grant_out), 32'h1);
        bus.req_in = '0;
        tick(4);

        // cache0 with both miss bits: write miss
        bus.req_in = 12'h006;
        tick();
        lit("rmwm grant", 32'(bus.grant_out), 32'h1);
        lit("rmwm snoop", 32'(bus.snoop_out), 32'h54);
        lit("rmwm mem_rd", 32'(bus.mem_rd_out), 32'h1);
        bus.req_in = '0;
        tick(4);

        // reset in the second write-back cycle
        bus.req_in = 12'h140;
        tick();
        lit("abort grant", 32'(bus.grant_out), 32'h4);
        bus.req_in = '0;
        tick();
        rst = 1'b0;
        tick();
        lit("abort outputs", {bus.grant_out, bus.snoop_out, bus.mem_rd_out, bus.mem_wr_out, bus.done_out, bus.busy_out}, 32'h0);
        rst = 1'b1;
        bus.req_in = 12'h104;
        tick();
        lit("post-reset grant", 32'(bus.grant_out), 32'h1);
        bus.req_in = '0;
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shared-bus arbiter and broadcaster that sits directly downstream of the per-cache MSI coherence controllers.
- Each controller presents its 3-bit {read_miss, write_miss, write_back} bus request.
- The arbiter grants one cache at a time, round-robin, and sequences memory write-back and fetch.
- For each miss it broadcasts a one-cycle snoop (bus read miss / bus write miss) to every other cache, then signals completion to the requester.

Parameters:
- NUM_CACHES, 4, number of attached cache controllers (2..8).
- MEM_LAT, 3, cycles each memory phase (write-back or fetch) occupies (>=1).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- req_in  input  3*NUM_CACHES  cache i request at bits [3i+2:3i] = {read_miss, write_miss, write_back}.
- grant_out  output  NUM_CACHES  one-hot grant, held for the whole transaction.
- snoop_out  output  2*NUM_CACHES  cache j at bits [2j+1:2j] = {bus_read_miss, bus_write_miss}; one-cycle pulse.
- mem_rd_out  output  1  one-cycle memory fetch command.
- mem_wr_out  output  1  one-cycle memory write-back command.
- done_out  output  NUM_CACHES  one-hot completion pulse to the granted cache.
- busy_out  output  1  high whenever state != IDLE.

Behaviour:
- Reset: sampled on posedge while rst==0. State=IDLE, all outputs 0, latched request=0, cnt=0, RR pointer=0. Reset overrides everything, including a transaction in progress; the aborted transaction gets no done_out.
- Outputs are registered; each takes effect on the edge that enters the corresponding state.
- States: IDLE, WB, MISS, DONE.
- IDLE:
  - A cache is eligible if its 3-bit request != 000.
  - Pick the first eligible cache scanning from the RR pointer upward, wrapping.
  - On that edge: set grant_out to the winner (one-hot), latch its request, go to WB if write_back=1, else MISS.
  - No eligible cache -> stay IDLE.
- Request semantics:
  - Requests are latched only at grant; changes to req_in during a transaction are ignored.
  - If read_miss and write_miss are both 1, the request is treated as a write miss.
- WB:
  - First cycle: mem_wr_out=1 (pulse only). Load cnt=MEM_LAT-1 and decrement each cycle.
  - When cnt==0: go to MISS if a miss bit is latched, else DONE.
  - WB lasts exactly MEM_LAT cycles.
- MISS:
  - First cycle: mem_rd_out=1 and snoop_out pulses for every cache j != granted.
  - Read miss sets bit 2j+1; write miss sets bit 2j. Granted cache's snoop bits stay 0.
  - Lasts MEM_LAT cycles (same counter scheme), then DONE.
- DONE:
  - One cycle with done_out = grant_out.
  - On exit: grant_out=0, RR pointer = (granted index + 1) mod NUM_CACHES, go to IDLE.
- Re-arbitration: at least one IDLE cycle between transactions. A cache still requesting after DONE is eligible, but lower priority per RR.
- Latency from grant edge:
  - Miss only: done at MEM_LAT cycles.
  - Write-back only: done at MEM_LAT cycles.
  - Write-back + miss: done at 2*MEM_LAT cycles.
- Invariants:
  - grant_out and done_out are always one-hot or zero.
  - mem_rd_out and mem_wr_out are never high in the same cycle.
  - snoop_out is nonzero only in the first MISS cycle.

Test Plan:
- NUM_CACHES=4, MEM_LAT=3, after reset: req cache1=100.
  - Edge after request: grant_out=0010, mem_rd_out=1, snoop_out=8'b10_10_00_10 for one cycle.
  - done_out=0010 three cycles later; busy_out low the cycle after that.
- req cache2=101 (read miss + write back):
  - mem_wr_out pulses at grant.
  - Three cycles later: mem_rd_out plus snoop read-miss pulses on caches 0,1,3.
  - done_out=0100 six cycles after grant.
- req cache3=001 only:
  - mem_wr_out pulse, no mem_rd_out, snoop_out stays 0.
  - done_out=1000 three cycles after grant.
- Caches 0 and 3 both request 010 continuously from reset:
  - grant 0001 first, then 1000, then 0001 (round-robin).
  - snoop_out bit 2j set for non-granted caches only.
- req cache0=110: treated as write miss; snoop_out=8'b01_01_01_00, mem_rd_out pulses.
- rst driven low during the second WB cycle:
  - Next edge: all outputs 0, busy_out=0, no done_out.
  - With caches 0 and 2 requesting after release: cache0 granted first (pointer reset).
